// File: rtl/servo_lock_supervisor.sv
// Lock-acquisition and rail-recovery supervisor for the PI/PD servo chain.
// Define LOCK_SWEEP_EN to build the SWEEP state and triangular sweep generator.
module servo_lock_supervisor #(
    parameter logic signed [15:0] RAIL_HI     = 16'sd32000,
    parameter logic signed [15:0] RAIL_LO     = -16'sd32000,
    parameter int                 RAIL_CYCLES = 1000,
    parameter logic        [15:0] LOCK_THRESH = 16'd256,
    parameter int                 LOCK_CYCLES = 10000,
    parameter int                 HOLD_CYCLES = 100,
    parameter logic signed [15:0] SWEEP_MIN   = -16'sd16384,
    parameter logic signed [15:0] SWEEP_MAX   = 16'sd16384,
    parameter logic        [15:0] SWEEP_STEP  = 16'd4
) (
    input  logic               clk_in,
    input  logic               rstn_in,
    input  logic               enable_in,
    input  logic signed [15:0] e_in,
    input  logic signed [15:0] servo_in,
    output logic               on_out,
    output logic               hold_out,
    output logic [1:0]         railed_out,
    output logic signed [15:0] sweep_out,
    output logic               locked_out,
    output logic [2:0]         state_out
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SWEEP   = 3'd1,
        S_ACQUIRE = 3'd2,
        S_LOCKED  = 3'd3,
        S_RAILED  = 3'd4
    } state_t;

    localparam int RAIL_W = $clog2(RAIL_CYCLES + 1);
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [RAIL_W-1:0] RAIL_MAX  = RAIL_W'(RAIL_CYCLES);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    localparam bit CFG_OK = (RAIL_LO < RAIL_HI) && (SWEEP_MIN < SWEEP_MAX) &&
                            (SWEEP_STEP != 16'd0);
    if (!CFG_OK) begin : g_bad_cfg
        $error("servo_lock_supervisor: inconsistent rail or sweep parameters");
    end

`ifdef LOCK_SWEEP_EN
    localparam state_t S_RESUME = S_SWEEP;
    localparam logic signed [16:0] STEP17 = {1'b0, SWEEP_STEP};
    localparam logic signed [16:0] MAX17  = {SWEEP_MAX[15], SWEEP_MAX};
    localparam logic signed [16:0] MIN17  = {SWEEP_MIN[15], SWEEP_MIN};
`else
    localparam state_t S_RESUME = S_ACQUIRE;
`endif

    // 17-bit magnitude so that -32768 maps to +32768 instead of wrapping
    function automatic logic [16:0] abs17(input logic signed [15:0] v);
        logic signed [16:0] w;
        w = {v[15], v};
        return w[16] ? 17'(-w) : 17'(w);
    endfunction

    function automatic int sat_inc(input int cnt, input int lim);
        return (cnt >= lim) ? lim : cnt + 1;
    endfunction

    state_t              state, state_nx;
    logic [RAIL_W-1:0]   rail_cnt, rail_cnt_nx;
    logic [LOCK_W-1:0]   lock_cnt, lock_cnt_nx;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nx;
    logic                in_win;
    logic                railed_any;
    logic                rail_evt;

    assign in_win     = abs17(e_in) <= {1'b0, LOCK_THRESH};
    assign railed_any = |railed_out;

`ifdef LOCK_SWEEP_EN
    logic signed [15:0] sweep_r, sweep_nx;
    logic signed [16:0] sweep_try;
    logic               dir_up, dir_up_nx;
`endif

    always_comb begin
        state_nx    = state;
        lock_cnt_nx = '0;
        hold_cnt_nx = '0;
        rail_cnt_nx = railed_any ? RAIL_W'(sat_inc(int'(rail_cnt), RAIL_CYCLES)) : '0;
        rail_evt    = rail_cnt_nx >= RAIL_MAX;
`ifdef LOCK_SWEEP_EN
        sweep_nx    = sweep_r;
        dir_up_nx   = dir_up;
        sweep_try   = '0;
`endif
        if (!enable_in) begin
            state_nx    = S_IDLE;
            rail_cnt_nx = '0;
`ifdef LOCK_SWEEP_EN
            sweep_nx    = '0;
            dir_up_nx   = 1'b1;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    state_nx = S_RESUME;
`ifdef LOCK_SWEEP_EN
                    dir_up_nx = 1'b1;
`endif
                end
`ifdef LOCK_SWEEP_EN
                S_SWEEP: begin
                    if (in_win) begin
                        state_nx = S_ACQUIRE;
                    end else begin
                        sweep_try = dir_up ? ({sweep_r[15], sweep_r} + STEP17)
                                           : ({sweep_r[15], sweep_r} - STEP17);
                        if (sweep_try >= MAX17) begin
                            sweep_nx  = SWEEP_MAX;
                            dir_up_nx = 1'b0;
                        end else if (sweep_try <= MIN17) begin
                            sweep_nx  = SWEEP_MIN;
                            dir_up_nx = 1'b1;
                        end else begin
                            sweep_nx  = sweep_try[15:0];
                        end
                    end
                end
`endif
                S_ACQUIRE: begin
                    // a rail event wins over a lock completing on the same cycle
                    if (rail_evt) begin
                        state_nx = S_RAILED;
                    end else if (in_win) begin
                        if (lock_cnt >= LOCK_LAST) state_nx = S_LOCKED;
                        else lock_cnt_nx = LOCK_W'(sat_inc(int'(lock_cnt), LOCK_CYCLES));
                    end
                end
                S_LOCKED: begin
                    if (rail_evt) state_nx = S_RAILED;
                end
                S_RAILED: begin
                    if (hold_cnt >= HOLD_LAST) state_nx = S_RESUME;
                    else hold_cnt_nx = HOLD_W'(sat_inc(int'(hold_cnt), HOLD_CYCLES));
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // outputs are decoded from the next state so they change on the same edge as state
    always_ff @(posedge clk_in) begin
        if (!rstn_in) begin
            state      <= S_IDLE;
            rail_cnt   <= '0;
            lock_cnt   <= '0;
            hold_cnt   <= '0;
            railed_out <= 2'b00;
            on_out     <= 1'b0;
            hold_out   <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            state      <= state_nx;
            rail_cnt   <= rail_cnt_nx;
            lock_cnt   <= lock_cnt_nx;
            hold_cnt   <= hold_cnt_nx;
            railed_out <= {servo_in >= RAIL_HI, servo_in <= RAIL_LO};
            on_out     <= (state_nx == S_ACQUIRE) || (state_nx == S_LOCKED);
            hold_out   <= (state_nx == S_RAILED);
            locked_out <= (state_nx == S_LOCKED);
        end
    end

`ifdef LOCK_SWEEP_EN
    always_ff @(posedge clk_in) begin
        if (!rstn_in) begin
            sweep_r <= '0;
            dir_up  <= 1'b1;
        end else begin
            sweep_r <= sweep_nx;
            dir_up  <= dir_up_nx;
        end
    end

    assign sweep_out = sweep_r;
`else
    assign sweep_out = '0;
`endif

    assign state_out = state;

endmodule

// File: tb/tb_servo_lock_supervisor.sv
// Directed plus randomized bench for servo_lock_supervisor against a run-length reference model.
// Honours LOCK_SWEEP_EN the same way as the design.
module tb_servo_lock_supervisor;

    localparam int RAIL_CYC = 8;
    localparam int LOCK_CYC = 20;
    localparam int HOLD_CYC = 5;
    localparam int SMAX     = 40;
    localparam int SMIN     = -16384;
    localparam int STEP     = 4;
    localparam int THRESH   = 256;
    localparam int RHI      = 32000;
    localparam int RLO      = -32000;
`ifdef LOCK_SWEEP_EN
    localparam bit SWEEP_EN = 1'b1;
`else
    localparam bit SWEEP_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rstn;
    logic               en;
    logic signed [15:0] e;
    logic signed [15:0] servo;
    logic               on, hold, locked;
    logic [1:0]         railed;
    logic signed [15:0] sweep;
    logic [2:0]         st;

    int checks   = 0;
    int failures = 0;

    // Reference model: mode uses the externally visible state numbering
    int         m_mode     = 0;
    int         m_sweep    = 0;
    bit         m_up       = 1'b1;
    int         m_lock_run = 0;
    int         m_rail_run = 0;
    int         m_hold     = 0;
    logic [1:0] m_railed   = 2'b00;

    always #5 clk = ~clk;

    servo_lock_supervisor #(
        .RAIL_HI    (16'sd32000),
        .RAIL_LO    (-16'sd32000),
        .RAIL_CYCLES(RAIL_CYC),
        .LOCK_THRESH(16'd256),
        .LOCK_CYCLES(LOCK_CYC),
        .HOLD_CYCLES(HOLD_CYC),
        .SWEEP_MIN  (-16'sd16384),
        .SWEEP_MAX  (16'sd40),
        .SWEEP_STEP (16'd4)
    ) dut (
        .clk_in    (clk),
        .rstn_in   (rstn),
        .enable_in (en),
        .e_in      (e),
        .servo_in  (servo),
        .on_out    (on),
        .hold_out  (hold),
        .railed_out(railed),
        .sweep_out (sweep),
        .locked_out(locked),
        .state_out (st)
    );

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        m_mode = 0; m_sweep = 0; m_up = 1'b1;
        m_lock_run = 0; m_rail_run = 0; m_hold = 0;
    endtask

    // Advance the model by one clock using the inputs applied during this cycle
    task automatic model_step();
        int  ae;
        int  nxt;
        bit  in_win;
        if (!rstn) begin
            clear_model();
            m_railed = 2'b00;
            return;
        end
        ae     = (e < 0) ? -int'(e) : int'(e);
        in_win = (ae <= THRESH);
        m_rail_run = (m_railed != 2'b00) ? m_rail_run + 1 : 0;
        m_railed   = {int'(servo) >= RHI, int'(servo) <= RLO};
        if (!en) begin
            clear_model();
            return;
        end
        case (m_mode)
            0: begin
                m_mode = SWEEP_EN ? 1 : 2;
                m_up = 1'b1;
                m_lock_run = 0;
            end
            1: begin
                if (in_win) begin
                    m_mode = 2;
                    m_lock_run = 0;
                end else begin
                    nxt = m_sweep + (m_up ? STEP : -STEP);
                    if (nxt >= SMAX) begin m_sweep = SMAX; m_up = 1'b0; end
                    else if (nxt <= SMIN) begin m_sweep = SMIN; m_up = 1'b1; end
                    else m_sweep = nxt;
                end
            end
            2: begin
                if (m_rail_run >= RAIL_CYC) begin
                    m_mode = 4; m_hold = 0;
                end else if (in_win) begin
                    m_lock_run++;
                    if (m_lock_run >= LOCK_CYC) m_mode = 3;
                end else begin
                    m_lock_run = 0;
                end
            end
            3: if (m_rail_run >= RAIL_CYC) begin m_mode = 4; m_hold = 0; end
            4: begin
                m_hold++;
                if (m_hold >= HOLD_CYC) begin
                    m_mode = SWEEP_EN ? 1 : 2;
                    m_lock_run = 0;
                end
            end
            default: m_mode = 0;
        endcase
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("state",  st,     m_mode);
        chk("on",     on,     (m_mode == 2) || (m_mode == 3));
        chk("hold",   hold,   m_mode == 4);
        chk("locked", locked, m_mode == 3);
        chk("railed", railed, m_railed);
        chk("sweep",  sweep,  m_sweep);
    endtask

    task automatic enter_acquire();
        en = 1'b0; e = 16'sd0; servo = 16'sd0;
        tick();
        en = 1'b1;
        tick();
`ifdef LOCK_SWEEP_EN
        tick();
`endif
        chk("enter_acquire", st, 2);
    endtask

    initial begin
        rstn = 1'b0; en = 1'b1; e = 16'sd0; servo = 16'sd32767;
        repeat (3) tick();
        chk("rst_state",  st,     0);
        chk("rst_on",     on,     0);
        chk("rst_hold",   hold,   0);
        chk("rst_railed", railed, 0);
        chk("rst_sweep",  sweep,  0);
        chk("rst_locked", locked, 0);

        rstn = 1'b1; e = 16'sd1000; servo = 16'sd0;
        tick();
`ifdef LOCK_SWEEP_EN
        chk("sweep_entry", st, 1);
        for (int k = 1; k <= 4120; k++) begin
            tick();
            if (k == 10)   chk("sweep_top",      sweep, 40);
            if (k == 11)   chk("sweep_reverse",  sweep, 36);
            if (k == 4116) chk("sweep_bottom",   sweep, -16384);
            if (k == 4117) chk("sweep_up_again", sweep, -16380);
        end
        e = 16'sd100;
        tick();
        chk("capture_state", st, 2);
        chk("capture_on",    on, 1);
        chk("capture_freeze", sweep, -16368);
`else
        chk("direct_acquire", st, 2);
        chk("no_sweep", sweep, 0);
`endif

        // capture window including both boundary values, then a single glitch
        e = -16'sd256; tick();
        e = 16'sd256;  tick();
        for (int i = 0; i < LOCK_CYC - 7; i++) begin
            e = 16'($signed($urandom_range(0, 512)) - 256);
            tick();
        end
        e = 16'sd300; tick();
        chk("glitch_restart", st, 2);
        for (int i = 0; i < LOCK_CYC - 1; i++) begin
            e = 16'($signed($urandom_range(0, 512)) - 256);
            tick();
        end
        chk("not_yet_locked", st, 2);
        e = 16'sd10; tick();
        chk("locked_state", st, 3);
        chk("locked_flag",  locked, 1);

        // rail recovery
        servo = 16'sd32000; tick();
        chk("rail_hi_lag", railed, 2'b10);
        repeat (RAIL_CYC - 1) tick();
        chk("rail_pre_event", st, 3);
        tick();
        chk("railed_state", st, 4);
        chk("railed_on",    on, 0);
        chk("railed_hold",  hold, 1);
        servo = 16'sd0; e = 16'sd1000;
        repeat (HOLD_CYC - 1) tick();
        chk("hold_still", st, 4);
        tick();
`ifdef LOCK_SWEEP_EN
        chk("resweep_state", st, 1);
        tick();
        chk("resweep_resume", sweep, -16364);
`else
        chk("reacquire_state", st, 2);
        chk("reacquire_sweep", sweep, 0);
`endif

        // rail compare boundaries and the -32768 magnitude corner
        servo = -16'sd32768; e = -16'sd32768; tick();
        chk("rail_lo_min", railed, 2'b01);
        servo = -16'sd32000; tick();
        chk("rail_lo_edge", railed, 2'b01);
        servo = -16'sd31999; tick();
        chk("rail_lo_inside", railed, 2'b00);
        servo = 16'sd31999; tick();
        chk("rail_hi_inside", railed, 2'b00);
        servo = 16'sd0; e = 16'sd0;
        repeat (10) tick();
        e = -16'sd32768; tick();
        e = 16'sd0;
        repeat (10) tick();
        chk("min_err_out_of_window", st, 2);

        // rail event and lock completion on the same cycle
        enter_acquire();
        repeat (11) tick();
        servo = 16'sd32000;
        repeat (8) tick();
        chk("race_pre", st, 2);
        tick();
        chk("rail_beats_lock", st, 4);

        en = 1'b0; tick();
        chk("disable_state", st, 0);
        chk("disable_sweep", sweep, 0);
        chk("disable_hold",  hold, 0);

        // randomized regimes
        servo = 16'sd0;
        for (int blk = 0; blk < 120; blk++) begin
            int len;
            int kind;
            len  = $urandom_range(5, 60);
            kind = $urandom_range(0, 9);
            for (int i = 0; i < len; i++) begin
                en   = ($urandom_range(0, 199) != 0);
                rstn = ($urandom_range(0, 499) != 0);
                if (kind <= 5 || kind >= 8)
                    e = 16'($signed($urandom_range(0, 512)) - 256);
                else if (kind == 6)
                    e = 16'($urandom_range(0, 65535));
                else
                    case ($urandom_range(0, 5))
                        0: e = -16'sd257;
                        1: e = -16'sd256;
                        2: e = 16'sd256;
                        3: e = 16'sd257;
                        4: e = -16'sd32768;
                        default: e = 16'sd32767;
                    endcase
                if (kind == 8)
                    servo = 16'($urandom_range(32000, 32767));
                else if (kind == 9)
                    servo = 16'($signed($urandom_range(0, 767)) - 32768);
                else
                    servo = 16'($signed($urandom_range(0, 63998)) - 31999);
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/servo_lock_supervisor.md
# servo_lock_supervisor

- Lock-acquisition and rail-recovery controller that sits downstream of the PI/PD servo chain and closes its control inputs.
- Watches the servo error and the servo output, and drives the servo's run enable, hold and railed flags.
- Generates a triangular sweep offset so the plant can be brought into capture range.
- On a rail event, turns the servo off (clearing the integrator), holds, and re-sweeps until lock is regained.

## Interface
- RAIL_HI, 16'sd32000, signed servo-output level at or above which the high rail is flagged
- RAIL_LO, -16'sd32000, signed servo-output level at or below which the low rail is flagged; must be < RAIL_HI
- RAIL_CYCLES, 1000, consecutive railed cycles before a rail event is declared
- LOCK_THRESH, 16'd256, |e_in| window for capture and lock
- LOCK_CYCLES, 10000, consecutive in-window cycles in ACQUIRE before LOCKED
- HOLD_CYCLES, 100, cycles spent in RAILED before re-sweep
- SWEEP_MIN, -16'sd16384, lower bound of sweep_out
- SWEEP_MAX, 16'sd16384, upper bound of sweep_out
- SWEEP_STEP, 16'd4, sweep increment per cycle
- clk_in  in  1  system clock (100 MHz)
- rstn_in  in  1  synchronous, active-low reset
- enable_in  in  1  supervisor enable; low forces IDLE
- e_in  in  16  signed error, same signal fed to the servo
- servo_in  in  16  signed servo output
- on_out  out  1  servo run enable
- hold_out  out  1  servo integrator hold
- railed_out  out  2  [1] = high rail, [0] = low rail
- sweep_out  out  16  signed sweep offset added to the actuator
- locked_out  out  1  high in LOCKED only
- state_out  out  3  current state encoding

## Operation
- States (state_out encoding): IDLE=0, SWEEP=1, ACQUIRE=2, LOCKED=3, RAILED=4.
- IDLE:
  - Outputs: on_out=0, hold_out=0, sweep_out=0.
  - enable_in=1 → SWEEP, direction up.
- SWEEP:
  - on_out=0.
  - sweep_out moves by ±SWEEP_STEP each cycle.
  - When the next value would pass SWEEP_MAX (or SWEEP_MIN), sweep_out clamps to the bound and the direction reverses.
  - |e_in| ≤ LOCK_THRESH → ACQUIRE; sweep_out freezes at its current value.
- ACQUIRE:
  - on_out=1.
  - lock_cnt counts consecutive cycles with |e_in| ≤ LOCK_THRESH and resets to 0 on any out-of-window cycle.
  - lock_cnt reaching LOCK_CYCLES−1 while in-window → LOCKED.
- LOCKED: on_out=1, locked_out=1; sweep_out stays frozen.
- Rail detection (all states): railed_out is the registered compare of servo_in ≥ RAIL_HI (bit 1) and servo_in ≤ RAIL_LO (bit 0).
- Rail event:
  - rail_cnt counts consecutive cycles with any railed_out bit set and resets to 0 otherwise.
  - rail_cnt reaching RAIL_CYCLES in ACQUIRE or LOCKED → RAILED.
- RAILED:
  - on_out=0, hold_out=1.
  - hold_cnt counts to HOLD_CYCLES, then → SWEEP, continuing from the frozen sweep_out in the same direction.
- Precedence:
  - enable_in=0 beats everything: next state is IDLE, sweep_out=0, all counters cleared.
  - A rail event beats lock completion when both occur on the same cycle.
- Arithmetic:
  - |e_in| is computed on 17 bits, so −32768 maps to 32768 (out of window).
  - The sweep next-value compare uses 17-bit signed arithmetic (no wrap).
  - Counters are wide enough for their parameter and saturate; they never wrap.

## Timing
- Reset: after a rstn_in-low edge, state=IDLE, and on_out, hold_out, railed_out, sweep_out, locked_out and state_out are all 0, with counters at 0. Reset mid-operation takes effect at the first rising edge while rstn_in is low.
- Every output is registered.
- railed_out lags servo_in by 1 cycle.
- A state change takes effect on the edge following its qualifying condition, and on_out, hold_out and locked_out update in that same cycle.
- The sweep step is applied every clock edge while in SWEEP.
- Minimum times:
  - LOCK_CYCLES cycles from entering ACQUIRE to LOCKED.
  - RAIL_CYCLES+1 cycles from servo_in railing to RAILED.

## Configuration
- Macro: LOCK_SWEEP_EN.
- Defined: sweep behaviour exactly as described above.
- Undefined:
  - The SWEEP state is not built and sweep_out is tied to 0.
  - IDLE goes directly to ACQUIRE when enable_in rises.
  - RAILED goes to ACQUIRE after HOLD_CYCLES.
  - state_out never shows 1.

## Test plan
- Reset check: hold rstn_in low with enable_in=1 and servo_in=32767 → all outputs 0, state_out=0.
- Sweep wrap: RAIL defaults, e_in=1000, SWEEP_MAX=40, STEP=4 → sweep_out 0,4,…,40,36,…, then clamps at −16384 and reverses.
- Capture and lock: set e_in=100 in SWEEP → state 2 on the next edge, on_out=1; after LOCK_CYCLES in-window cycles → locked_out=1, state 3. A single e_in=300 glitch in ACQUIRE restarts the count.
- Rail recovery: in LOCKED, drive servo_in=32000 → railed_out=2'b10 after 1 cycle; after RAIL_CYCLES → state 4, on_out=0, hold_out=1; after HOLD_CYCLES → state 1, with sweep resuming from its frozen value.
- Edge cases: drive servo_in=−32768 with e_in=−32768 → railed_out=2'b01, and e_in is treated as out of window. Drop enable_in in any state → IDLE with sweep_out=0 on the next edge.
- Macro off: with LOCK_SWEEP_EN undefined, set enable_in=1 → state 2 directly and sweep_out stays 0.
